// File: rtl/cmos_capture_ctrl.sv
// rtl/cmos_capture_ctrl.sv - DVP frame sequencer: skip settling frames, gate whole frames, check geometry
//
// Ports:
//   i_pclk        sensor pixel clock, rising edge
//   rst_n         synchronous active-low reset
//   i_cfg_done    sensor configuration complete (level)
//   i_cap_en      capture enable (level)
//   i_vsync       DVP VSYNC, active-high blanking; frame starts at falling edge
//   i_href        DVP HREF, high during active bytes
//   i_pdata[7:0]  DVP data byte
//   o_de          gated HREF to the pixel packer (1 cycle latency)
//   o_pdata[7:0]  registered data byte to the pixel packer
//   o_frame_start pulse when a captured frame begins
//   o_frame_done  pulse when a captured frame ends
//   o_frame_ok    geometry result, valid with o_frame_done
//   o_err_sticky  set on any bad frame, cleared only by reset
//   o_line_cnt    lines completed in the current frame
//   o_busy        high while capturing
module cmos_capture_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        i_pclk,
    input  logic        rst_n,
    input  logic        i_cfg_done,
    input  logic        i_cap_en,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_pdata,
    output logic        o_de,
    output logic [7:0]  o_pdata,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic        o_err_sticky,
    output logic [11:0] o_line_cnt,
    output logic        o_busy
);

    localparam logic [12:0] LINE_BYTES  = 13'(2 * H_ACTIVE);
    localparam logic [11:0] FRAME_LINES = 12'(V_ACTIVE);
    localparam logic [15:0] SKIP_TARGET = 16'(SKIP_FRAMES);
    localparam logic [12:0] BYTE_MAX    = 13'h1fff;
    localparam logic [11:0] LINE_MAX    = 12'hfff;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        ARMED   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        vs_d;
    logic        hr_d;
    logic        vs_fall;
    logic        vs_rise;
    logic        hr_fall;

    logic [15:0] skip_cnt;
    logic [12:0] byte_cnt;
    logic        line_bad;

    logic        start_frame;
    logic        end_frame;
    logic        line_end;
    logic        byte_inc;
    logic [11:0] line_cnt_nxt;
    logic        line_bad_nxt;
    logic        frame_ok_nxt;

    assign vs_fall = vs_d & ~i_vsync;
    assign vs_rise = ~vs_d & i_vsync;
    assign hr_fall = hr_d & ~i_href;

    // State register
    always_ff @(posedge i_pclk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; losing sensor configuration aborts from any state
    always_comb begin
        state_nxt = state;
        if (!i_cfg_done) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SKIP;
                SKIP:    if (skip_cnt == SKIP_TARGET) state_nxt = ARMED;
                ARMED:   if (vs_fall && i_cap_en) state_nxt = CAPTURE;
                CAPTURE: if (vs_rise) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control strobes and the post-update line/frame evaluation. The frame
    // verdict uses the counts as they will be after this cycle, so a line
    // ending on the same cycle as VSYNC rising is counted before judging.
    always_comb begin
        start_frame  = (state == ARMED) && (state_nxt == CAPTURE);
        end_frame    = (state == CAPTURE) && i_cfg_done && vs_rise;
        line_end     = (state == CAPTURE) && hr_fall;
        byte_inc     = (state == CAPTURE) && i_href;
        line_cnt_nxt = o_line_cnt;
        line_bad_nxt = line_bad;
        if (line_end) begin
            if (o_line_cnt != LINE_MAX) line_cnt_nxt = o_line_cnt + 12'd1;
            if (byte_cnt != LINE_BYTES) line_bad_nxt = 1'b1;
        end
        frame_ok_nxt = !line_bad_nxt && (line_cnt_nxt == FRAME_LINES);
    end

    // Datapath and counters
    always_ff @(posedge i_pclk) begin
        if (!rst_n) begin
            vs_d          <= 1'b0;
            hr_d          <= 1'b0;
            skip_cnt      <= '0;
            byte_cnt      <= '0;
            line_bad      <= 1'b0;
            o_line_cnt    <= '0;
            o_de          <= 1'b0;
            o_pdata       <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_err_sticky  <= 1'b0;
        end else begin
            vs_d <= i_vsync;
            hr_d <= i_href;

            if (state == IDLE) begin
                skip_cnt <= '0;
            end else if (state == SKIP && vs_rise) begin
                skip_cnt <= skip_cnt + 16'd1;
            end

            o_frame_start <= start_frame;
            o_frame_done  <= end_frame;
            o_frame_ok    <= end_frame && frame_ok_nxt;
            if (end_frame && !frame_ok_nxt) o_err_sticky <= 1'b1;

            if (start_frame) begin
                o_line_cnt <= '0;
                byte_cnt   <= '0;
                line_bad   <= 1'b0;
            end else if (state == CAPTURE) begin
                o_line_cnt <= line_cnt_nxt;
                line_bad   <= line_bad_nxt;
                if (line_end) begin
                    byte_cnt <= '0;
                end else if (byte_inc && byte_cnt != BYTE_MAX) begin
                    byte_cnt <= byte_cnt + 13'd1;
                end
            end

            // i_cfg_done gates o_de so an abort silences the packer immediately
            o_de <= (state == CAPTURE) && i_cfg_done && i_href;
            if (state == CAPTURE) o_pdata <= i_pdata;
        end
    end

    assign o_busy = (state == CAPTURE);

endmodule
